uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer between uart_rx and the CPU peripheral read mux. Drains bytes from uart_rx
//  (valid/read handshake) into a DEPTH-entry FIFO and presents the head byte on the
//  PERI_UART read path. Drives a fill-level RTS for flow control. Lets software read bursts
//  without losing bytes while the CPU is busy on SPI fetches.
// PARAMETERS
//  DEPTH          8          entries; power of 2, >= 2
//  RTS_THRESHOLD  DEPTH-2    rts asserted when level >= this; range 1..DEPTH
// PORTS
//  clk        in   1   core clock; all logic on posedge
//  resetn     in   1   asynchronous, active-low reset
//  in_valid   in   1   uart_rx_valid; level, held until acknowledged
//  in_data    in   8   uart_rx_data; stable while in_valid
//  in_ack     out  1   one-cycle pulse to uart_rx_read; byte captured
//  rd_en      in   1   CPU read strobe (is_data_in && PERI_UART)
//  rd_data    out  8   head byte; 8'h00 when empty
//  rd_valid   out  1   FIFO non-empty (status bit 1 replacement)
//  level      out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
//  rts        out  1   1 = request sender to pause (level >= RTS_THRESHOLD)
// BEHAVIOUR
//  - Reset (async): rd_ptr=wr_ptr=0, level=0, in_ack=0, holdoff=0, rts=0; rd_valid=0,
//    rd_data=8'h00. Memory contents not reset.
//  - Push: when in_valid && !holdoff && level<DEPTH (current-cycle level): write in_data at
//    wr_ptr, wr_ptr++ (wraps mod DEPTH), in_ack=1 for exactly that next cycle; holdoff=1 for
//    that cycle, so in_valid is ignored for one cycle while uart_rx deasserts valid. Max push
//    rate one byte per 2 cycles.
//  - Full (level==DEPTH): no push, in_ack stays 0, byte remains in uart_rx. Push blocked
//    even if a pop occurs the same cycle; resumes the cycle after.
//  - Pop: rd_en && level>0 -> rd_ptr++ (wraps). rd_en when empty ignored, no state change.
//  - rd_data = mem[rd_ptr] when level>0 else 8'h00; combinational from registered state.
//    Byte written at posedge N visible on rd_data/rd_valid after posedge N (zero added
//    latency). After pop at posedge N, next byte is on rd_data after posedge N.
//  - Simultaneous push+pop with 0<level<DEPTH: both pointers advance, level unchanged.
//  - level: +1 push only, -1 pop only, unchanged otherwise; never exceeds DEPTH, never < 0.
//  - rts registered from next level: rts=1 iff level >= RTS_THRESHOLD after the update.
//  - Reset mid-operation: pending in_ack pulse is cancelled; buffered bytes are discarded.
//  - Ordering strictly FIFO; no byte duplicated or dropped while handshake is obeyed.
// CONFIGURATION
//  UART_RX_FIFO_FLUSH_EN defined: adds port `flush in 1`. flush=1 at a posedge sets
//   rd_ptr=wr_ptr, level=0, rts=0. It takes priority over push/pop that cycle: no push,
//   no in_ack. holdoff is cleared.
//  Not defined: no flush port; the FIFO empties only by reads or reset.
// TESTING
//  1. Reset -> rd_valid=0, rd_data=00, level=0, rts=0, in_ack=0; rd_en while empty keeps all.
//  2. uart_rx model presents 41,42,43 -> in_ack 1-cycle pulse each, >=1 idle cycle between;
//     level=3; three rd_en -> rd_data 41,42,43 in order, then 00, rd_valid=0.
//  3. DEPTH=8: push 8 bytes with no reads -> level=8, rts=1 from level 6; 9th byte held,
//     in_ack=0. One rd_en -> 9th byte accepted the following cycle; level back to 8.
//  4. Push 8, pop 8, push 8, pop 8 with interleaving -> pointer wrap, data order intact
//     (bytes 00..0F).
//  5. Hold level=4; assert rd_en in the same cycle as the push -> level stays 4, order intact.
//  6. Assert resetn low between push and in_ack -> in_ack stays 0, level=0. With
//     UART_RX_FIFO_FLUSH_EN, flush at level=5 with rd_en -> level=0, rts=0, no in_ack.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO between uart_rx and the CPU read path, with fill-level rts.
// Ports: clk, resetn (async active-low); in_valid/in_data/in_ack (uart_rx handshake);
// rd_en/rd_data/rd_valid (CPU read of head byte, 00 when empty); level (occupancy); rts.
// Define UART_RX_FIFO_FLUSH_EN to add input flush, which empties the FIFO at a posedge.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int RTS_THRESHOLD = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ack,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   rts
`ifdef UART_RX_FIFO_FLUSH_EN
  ,
  input  logic                   flush
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [AW:0] THR = RTS_THRESHOLD[AW:0];
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level_nxt;
  logic push, pop, fl;
`ifdef UART_RX_FIFO_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  // in_ack doubles as the holdoff: uart_rx still shows the old byte during the ack cycle
  assign push = in_valid && !in_ack && level != FULL && !fl;
  assign pop = rd_en && rd_valid && !fl;
  assign level_nxt = fl ? '0 : level + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_valid = level != '0;
  assign rd_data = rd_valid ? mem[rd_ptr] : 8'h00;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      in_ack <= 1'b0;
      rts <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= fl ? wr_ptr : rd_ptr + AW'(pop);
      level <= level_nxt;
      in_ack <= push;
      rts <= level_nxt >= THR;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized scoreboard bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int THR = DEPTH - 2;
  logic clk = 0, resetn = 1, in_valid = 0, rd_en = 0, fl = 0;
  logic [7:0] in_data = 0;
  logic in_ack, rd_valid, rts;
  logic [7:0] rd_data;
  logic [$clog2(DEPTH):0] level;
  int total = 0, passed = 0;
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit exp_ack = 0, stale = 0;
  logic [7:0] seq = 8'h41;
  always #5 clk = ~clk;
  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .rts(rts)
`ifdef UART_RX_FIFO_FLUSH_EN
    , .flush(fl)
`endif
  );
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask
  task automatic check_state();
    int n = mq.size();
    chk("in_ack", int'(in_ack), int'(exp_ack));
    chk("level", int'(level), n);
    chk("rd_valid", int'(rd_valid), int'(n > 0));
    chk("rts", int'(rts), int'(n >= THR));
    chk("rd_data", int'(rd_data), n > 0 ? int'(mq[0]) : 0);
  endtask
  // bytes leave the FIFO in the order they were accepted
  always @(negedge clk)
    if (resetn && rd_en && rd_valid && !fl) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("rd_order", int'(rd_data), int'(sb.pop_front()));
    end
  task automatic step(input int ps, input int pr, input int pf);
    bit push, pop;
    @(posedge clk);
    #1;
    check_state();
    if (exp_ack) begin
      stale = 1;
      if ($urandom_range(1) == 0) in_valid = 0;
    end else if (stale) begin
      stale = 0;
      in_valid = 0;
    end else if (!in_valid && $urandom_range(99) < ps) begin
      in_valid = 1;
      in_data = seq;
      seq++;
    end
    rd_en = $urandom_range(99) < pr;
    fl = $urandom_range(99) < pf;
    push = in_valid && !exp_ack && mq.size() < DEPTH && !fl;
    pop = rd_en && mq.size() > 0 && !fl;
    if (fl) begin
      mq.delete();
      sb.delete();
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(in_data);
      sb.push_back(in_data);
    end
    exp_ack = push;
  endtask
  task automatic mid_reset(input bit after_edge);
    for (int i = 0; i < 50 && !exp_ack; i++) step(100, 0, 0);
    if (!exp_ack) chk("reset_setup", 0, 1);
    if (after_edge) @(posedge clk);
    #2;
    resetn = 0;
    in_valid = 0;
    rd_en = 0;
    fl = 0;
    mq.delete();
    sb.delete();
    exp_ack = 0;
    stale = 0;
    #1;
    check_state();
    @(negedge clk);
    resetn = 1;
  endtask
  initial begin
    #1 resetn = 0;
    #2 check_state();
    @(negedge clk) resetn = 1;
    repeat (4) step(0, 100, 0);
    repeat (12) step(100, 0, 0);
    repeat (20) step(0, 100, 0);
    repeat (40) step(100, 0, 0);
    repeat (8) step(100, 25, 0);
    repeat (30) step(0, 100, 0);
    seq = 8'h00;
    repeat (400) step(60, 50, 0);
    repeat (300) step(95, 35, 0);
    mid_reset(0);
    repeat (10) step(100, 0, 0);
    mid_reset(1);
    repeat (100) step(70, 40, 0);
`ifdef UART_RX_FIFO_FLUSH_EN
    repeat (400) step(80, 30, 3);
`endif
    repeat (30) step(0, 100, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
